word_copier: RTL
================

# word_copier

Bus initiator for the word-granular memory-mapped register interface: drives `re`/`we`/`addr`/`wd` and samples `rd`, the same signal set a mapped register bank responds to. On a start command it copies `len` consecutive 32-bit words from a source word address to a destination word address. It sits beside the core as a small block-move engine for peripheral register banks and scratch RAM, with the peripheral-side responder connected directly to its bus ports.

## Interface
- `MAX_WORDS`, default 256: largest transfer length; `CW = $clog2(MAX_WORDS + 1)` is the width of `len`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `start`  in  1  command strobe; sampled only in IDLE.
- `src`  in  [31:2]  source word address; sampled with `start`.
- `dst`  in  [31:2]  destination word address; sampled with `start`.
- `len`  in  CW  word count, 0..MAX_WORDS; sampled with `start`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `re`  out  1  bus read enable.
- `rd`  in  [31:0]  bus read data; combinational response, valid in the same cycle as `re`/`addr`.
- `we`  out  1  bus write enable.
- `wd`  out  [31:0]  bus write data.
- `addr`  out  [31:2]  bus word address.

## Operation
- States: IDLE, READ, WRITE.
- IDLE: `start=1` with `len>0` latches `src`, `dst` and `len` into internal registers, then goes to READ. `start=1` with `len=0` stays in IDLE and pulses `done` on the next cycle; no bus access is made. `start=0` stays in IDLE.
- READ: `re=1`, `we=0`, `addr=src_reg`. The block captures `rd` into a data buffer at the clock edge, increments `src_reg`, then goes to WRITE.
- WRITE: `we=1`, `re=0`, `addr=dst_reg`, `wd=buffer`. The block increments `dst_reg` and decrements the remaining count. It goes to READ if the remaining count is still above 0. Otherwise it goes to IDLE and pulses `done`.
- `start` outside IDLE is ignored; no queueing.
- Address arithmetic is 30-bit modulo: word address 0x3FFF_FFFF increments to 0.
- The copy always runs in ascending order. Overlapping ranges with `dst > src` replicate data; this is required behaviour and is not corrected.
- `re` and `we` are never high together.
- Reset in any state returns the block to IDLE immediately. A partially completed transfer is abandoned and `done` is not pulsed.
- Reset values: `busy=0`, `done=0`, `re=0`, `we=0`, `addr=0`, `wd=0`, buffer 0, count 0.

## Timing
- All outputs are registered.
- Cycle 0: IDLE samples `start`.
- Cycle 1: first READ.
- Cycle 2: first WRITE.
- Word k (k from 0) is read in cycle 2k+1 and written in cycle 2k+2.
- `busy=1` from cycle 1 through cycle 2·len. The cycle-0 edge sets it and the final-WRITE edge clears it.
- `done=1` only in cycle 2·len+1, together with `busy=0`. The block is in IDLE in that cycle, so a `start` in the same cycle is accepted.
- Throughput: 2 cycles per word. Latency from `start` to `done` is 2·len+1 cycles.
- For `len=0`: `done=1` in cycle 1, and `busy` stays 0.

## Configuration
- `WORD_COPIER_FILL_EN` defined:
  - Adds input `fill` (1 bit) and input `pattern` ([31:0]), both sampled with `start`.
  - With `fill=1`, the block skips READ entirely. It writes `pattern` to `dst..dst+len-1` on consecutive WRITE cycles at 1 cycle per word, with `re` held at 0.
  - Fill timing: `busy` from cycle 1 to cycle len; `done` in cycle len+1.
  - `fill=0` behaves exactly like the copy.
- `WORD_COPIER_FILL_EN` undefined: ports `fill` and `pattern` do not exist and every transfer is a copy.

## Test plan
- Copy basic: memory words 0x10..0x13 = A0,A1,A2,A3; `start`, `src=0x10`, `dst=0x20`, `len=4` -> words 0x20..0x23 = A0..A3; `done` in cycle 9; `busy` high in cycles 1..8.
- Zero length: `start`, `len=0` -> `done` in cycle 1; `re` and `we` never asserted; `busy` stays 0.
- Wrap and back-to-back:
  - `src=0x3FFF_FFFF`, `len=2` -> reads hit 0x3FFF_FFFF then 0x0.
  - `start` asserted again in the `done` cycle -> second transfer's READ occurs in the next cycle.
- Ignore and reset:
  - `start` pulsed while busy -> no effect on the current transfer.
  - `rst_n=0` after word 1 of a 4-word copy -> IDLE, all outputs 0, no `done`, destination word 2 unwritten.
- Overlap: `src=0x10`, `dst=0x11`, `len=3`, memory 0x10 = 0x5 -> words 0x11..0x13 all = 0x5.
- Fill (macro defined): `fill=1`, `pattern=0xDEADBEEF`, `dst=0x40`, `len=3` -> writes in cycles 1..3, `re` never high, `done` in cycle 4.

Source files
------------

// File: rtl/word_copier.sv
// word_copier: bus-initiator block-move engine, copies len words src -> dst.
// Optional WORD_COPIER_FILL_EN adds a 1-cycle-per-word pattern fill mode.
module word_copier #(
  parameter  int MAX_WORDS = 256,
  localparam int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [31:2]   src_i,
  input  logic [31:2]   dst_i,
  input  logic [CW-1:0] len_i,
`ifdef WORD_COPIER_FILL_EN
  input  logic          fill_i,
  input  logic [31:0]   pattern_i,
`endif
  output logic          busy_o,
  output logic          done_o,
  output logic          re_o,
  input  logic [31:0]   rd_i,
  output logic          we_o,
  output logic [31:0]   wd_o,
  output logic [31:2]   addr_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:2]   src_q, src_d;
  logic [31:2]   dst_q, dst_d;
  logic [31:2]   addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   buf_q, buf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          re_q, re_d;
  logic          we_q, we_d;
  logic          fill_q, fill_d;

  logic          fill_s;
  logic [31:0]   pattern_s;

`ifdef WORD_COPIER_FILL_EN
  assign fill_s    = fill_i;
  assign pattern_s = pattern_i;
`else
  assign fill_s    = 1'b0;
  assign pattern_s = '0;
`endif

  // Outputs for the next cycle are computed here so every port is a flop.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    busy_d  = busy_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    re_d    = 1'b0;
    we_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_d  = len_i;
            busy_d = 1'b1;
            src_d  = src_i;
            dst_d  = dst_i;
            fill_d = fill_s;
            if (fill_s) begin
              buf_d   = pattern_s;
              addr_d  = dst_i;
              we_d    = 1'b1;
              state_d = WRITE;
            end else begin
              addr_d  = src_i;
              re_d    = 1'b1;
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        buf_d   = rd_i;
        src_d   = src_q + 30'd1;
        addr_d  = dst_q;
        we_d    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        dst_d = dst_q + 30'd1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q > CW'(1)) begin
          if (fill_q) begin
            addr_d  = dst_q + 30'd1;
            we_d    = 1'b1;
            state_d = WRITE;
          end else begin
            addr_d  = src_q;
            re_d    = 1'b1;
            state_d = READ;
          end
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      re_q    <= re_d;
      we_q    <= we_d;
      fill_q  <= fill_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign re_o   = re_q;
  assign we_o   = we_q;
  assign wd_o   = buf_q;
  assign addr_o = addr_q;

endmodule
